// File: rtl/sdcard_cmd_ctrl.sv
// rtl/sdcard_cmd_ctrl.sv - SD-card SPI-mode command sequencer (optional internal CRC7: SDCARD_CMD_CRC7_EN)
module sdcard_cmd_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic [2:0]  resp_len,
  input  logic [7:0]  clk_div,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_data,
  output logic [7:0]  spi_data_out,
  output logic [4:0]  spi_bits,
  output logic [7:0]  spi_divider,
  output logic        spi_start,
  input  logic [7:0]  spi_data_in,
  input  logic        spi_finished
);

  typedef enum logic [2:0] {IDLE, PRE, CMD, SCAN, RESP, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [2:0]  len_q;
  logic [2:0]  cnt;
  logic        pending;
  logic [6:0]  crc7;
  logic [7:0]  frame_byte;
  logic        accept;
  logic        xfer_ok;

  assign accept  = (state == IDLE) && cmd_start;
  // a finish only counts when a transfer of ours is outstanding
  assign xfer_ok = pending && spi_finished;

  // select the current command frame byte from the byte counter
  always_comb begin
    frame_byte = 8'hFF;
    case (cnt)
      3'd0:    frame_byte = {2'b01, idx_q};
      3'd1:    frame_byte = arg_q[31:24];
      3'd2:    frame_byte = arg_q[23:16];
      3'd3:    frame_byte = arg_q[15:8];
      3'd4:    frame_byte = arg_q[7:0];
      3'd5:    frame_byte = {crc7, 1'b1};
      default: frame_byte = 8'hFF;
    endcase
  end

`ifdef SDCARD_CMD_CRC7_EN
  logic [6:0] crc_q;

  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic [7:0] b);
    logic [6:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[6] ^ b[i];
      r  = {r[5:0], 1'b0};
      if (fb) r = r ^ 7'h09;
    end
    return r;
  endfunction

  // fold each of the first five frame bytes in as it completes; ready before byte 5 is shown
  always_ff @(posedge clk) begin
    if (rst)                                          crc_q <= 7'd0;
    else if (accept)                                  crc_q <= 7'd0;
    else if (state == CMD && xfer_ok && cnt < 3'd5)   crc_q <= crc7_next(crc_q, frame_byte);
  end
  assign crc7 = crc_q;
`else
  logic [6:0] crc_q;

  // caller-supplied CRC, captured with the rest of the command
  always_ff @(posedge clk) begin
    if (rst)         crc_q <= 7'd0;
    else if (accept) crc_q <= cmd_crc;
  end
  assign crc7 = crc_q;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and engine-facing outputs; reset forces the idle output values
  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    done         = 1'b0;
    spi_start    = 1'b0;
    spi_bits     = 5'd0;
    spi_data_out = 8'hFF;
    case (state)
      IDLE: if (cmd_start) state_nxt = PRE;
      PRE: begin
        busy = 1'b1; spi_bits = 5'd7; spi_start = !pending;
        if (xfer_ok) state_nxt = CMD;
      end
      CMD: begin
        busy = 1'b1; spi_bits = 5'd7; spi_start = !pending; spi_data_out = frame_byte;
        if (xfer_ok && cnt == 3'd5) state_nxt = SCAN;
      end
      SCAN: begin
        busy = 1'b1; spi_bits = 5'd31; spi_start = !pending;
        if (xfer_ok) begin
          if (spi_data_in[7])      state_nxt = DONE;
          else if (len_q != 3'd0)  state_nxt = RESP;
          else                     state_nxt = DONE;
        end
      end
      RESP: begin
        busy = 1'b1; spi_bits = 5'd7; spi_start = !pending;
        if (xfer_ok && cnt == len_q - 3'd1) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1; state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      busy = 1'b0; done = 1'b0; spi_start = 1'b0; spi_bits = 5'd0; spi_data_out = 8'hFF;
    end
  end

  // command capture, transfer bookkeeping and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 6'd0; arg_q <= 32'd0; len_q <= 3'd0; cnt <= 3'd0; pending <= 1'b0;
      timeout <= 1'b0; resp_r1 <= 8'h00; resp_data <= 32'd0; spi_divider <= 8'd0;
    end else begin
      if (accept) begin
        idx_q       <= cmd_index;
        arg_q       <= cmd_arg;
        len_q       <= (resp_len > 3'd4) ? 3'd4 : resp_len;
        spi_divider <= clk_div;
        cnt         <= 3'd0;
        pending     <= 1'b0;
        timeout     <= 1'b0;
        resp_r1     <= 8'h00;
        resp_data   <= 32'd0;
      end
      if (spi_start)    pending <= 1'b1;
      else if (xfer_ok) pending <= 1'b0;
      if (xfer_ok) begin
        case (state)
          CMD:  cnt <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
          SCAN: begin
            resp_r1 <= spi_data_in;
            if (spi_data_in[7]) timeout <= 1'b1;
          end
          RESP: begin
            resp_data <= {resp_data[23:0], spi_data_in};
            cnt       <= cnt + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdcard_cmd_ctrl.sv
// tb/tb_sdcard_cmd_ctrl.sv - self-checking bench for sdcard_cmd_ctrl with a random-latency engine model
module tb_sdcard_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic [2:0]  resp_len;
  logic [7:0]  clk_div;
  logic        busy, done, timeout, spi_start, spi_finished;
  logic [7:0]  resp_r1, spi_data_out, spi_divider, spi_data_in;
  logic [31:0] resp_data;
  logic [4:0]  spi_bits;

  sdcard_cmd_ctrl dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .cmd_crc(cmd_crc), .resp_len(resp_len), .clk_div(clk_div), .busy(busy), .done(done),
    .timeout(timeout), .resp_r1(resp_r1), .resp_data(resp_data), .spi_data_out(spi_data_out),
    .spi_bits(spi_bits), .spi_divider(spi_divider), .spi_start(spi_start),
    .spi_data_in(spi_data_in), .spi_finished(spi_finished)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // engine model: one log entry {bits, data} per spi_start, random finish latency
  logic [12:0] log_q[$];
  logic [12:0] cur;
  logic [7:0]  r1_cfg, resp_byte;
  logic [31:0] data_cfg;
  int          viol = 0;
  int          lat;
  bit          outst;

  initial begin
    spi_finished = 1'b0;
    spi_data_in  = 8'h00;
    outst        = 1'b0;
    forever begin
      @(negedge clk);
      spi_finished = 1'b0;
      spi_data_in  = 8'($urandom);
      if (rst) begin
        outst = 1'b0;
      end else if (outst) begin
        if (spi_start) viol++;
        if ({spi_bits, spi_data_out} !== cur) viol++;
        if (lat == 0) begin
          spi_finished = 1'b1;
          spi_data_in  = resp_byte;
          outst        = 1'b0;
        end else begin
          lat--;
        end
      end else if (spi_start) begin
        int k;
        cur = {spi_bits, spi_data_out};
        log_q.push_back(cur);
        k = log_q.size() - 1;
        if (k == 7)                 resp_byte = r1_cfg;
        else if (k >= 8 && k <= 11) resp_byte = 8'(data_cfg >> (8 * (11 - k)));
        else                        resp_byte = 8'($urandom);
        outst = 1'b1;
        lat   = $urandom_range(0, 20);
      end
    end
  end

  // CRC7 as the remainder of msg*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc_model(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                         input logic [2:0] len, input logic [7:0] r1, input logic [31:0] dat,
                         input logic [7:0] div, input bit inject, input bit chk_last,
                         input logic [7:0] exp_last, input string tag);
    logic [12:0] exp_q[$];
    logic [6:0]  c;
    logic [31:0] exp_data;
    int          n, cyc, bad;
    bit          injected;
    log_q.delete();
    r1_cfg = r1; data_cfg = dat;
    n = (len > 3'd4) ? 4 : int'(len);
`ifdef SDCARD_CMD_CRC7_EN
    c = crc_model({2'b01, idx, arg});
`else
    c = crc;
`endif
    exp_q.push_back({5'd7, 8'hFF});
    exp_q.push_back({5'd7, 2'b01, idx});
    for (int b = 3; b >= 0; b--) exp_q.push_back({5'd7, 8'(arg >> (8 * b))});
    exp_q.push_back({5'd7, c, 1'b1});
    exp_q.push_back({5'd31, 8'hFF});
    if (!r1[7]) for (int b = 0; b < n; b++) exp_q.push_back({5'd7, 8'hFF});
    exp_data = (r1[7] || n == 0) ? 32'd0 : (dat >> (8 * (4 - n)));

    @(negedge clk);
    cmd_index = idx; cmd_arg = arg; cmd_crc = crc; resp_len = len; clk_div = div; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    chk({tag, " busy_after_accept"}, busy, 1'b1);
    cyc = 0; injected = 0;
    while (done !== 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (inject && !injected && log_q.size() == 3 && done !== 1'b1) begin
        cmd_index = ~idx; cmd_arg = ~arg; cmd_crc = ~crc; resp_len = 3'd0; clk_div = ~div;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0; injected = 1; cyc++;
      end
    end
    chk({tag, " done_seen"}, done, 1'b1);
    chk({tag, " busy_at_done"}, busy, 1'b0);
    chk({tag, " resp_r1"}, resp_r1, r1);
    chk({tag, " timeout"}, timeout, r1[7]);
    chk({tag, " resp_data"}, resp_data, exp_data);
    chk({tag, " spi_divider"}, spi_divider, div);
    bad = (log_q.size() != exp_q.size()) ? 1 : 0;
    if (bad == 0) for (int i = 0; i < exp_q.size(); i++) if (log_q[i] !== exp_q[i]) bad++;
    chk({tag, " transfer_list"}, 64'(bad), 64'd0);
    if (chk_last && log_q.size() >= 7) chk({tag, " last_cmd_byte"}, log_q[6][7:0], exp_last);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 1'b0);
  endtask

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic [2:0]  len;
    logic [7:0]  r1;
    logic [31:0] dat;
    logic [7:0]  div;
    bit          chk_last;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cnt_done, cnt_start, cyc;
    vecs[0] = '{6'd0,  32'h0000_0000, 7'h4A, 3'd0, 8'h01, 32'h0,          8'h10, 1, 8'h95};
    vecs[1] = '{6'd8,  32'h0000_01AA, 7'h43, 3'd4, 8'h01, 32'h0000_01AA,  8'h02, 1, 8'h87};
`ifdef SDCARD_CMD_CRC7_EN
    vecs[2] = '{6'd17, 32'h1234_5678, 7'h2A, 3'd1, 8'h00, 32'hC300_0000,  8'h04, 0, 8'h00};
`else
    vecs[2] = '{6'd17, 32'h1234_5678, 7'h2A, 3'd1, 8'h00, 32'hC300_0000,  8'h04, 1, 8'h55};
`endif
    vecs[3] = '{6'd55, 32'h0000_0000, 7'h32, 3'd4, 8'hFF, 32'hDEAD_BEEF,  8'h08, 0, 8'h00};
    vecs[4] = '{6'd58, 32'hA5A5_0F0F, 7'h11, 3'd7, 8'h00, 32'h8001_7E3C,  8'hFF, 0, 8'h00};
    vecs[5] = '{6'd16, 32'h0000_0200, 7'h0A, 3'd2, 8'h05, 32'h1234_0000,  8'h01, 0, 8'h00};

    rst = 1'b1; cmd_start = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0; cmd_crc = 7'd0;
    resp_len = 3'd0; clk_div = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_spi_start", spi_start, 1'b0);
    chk("reset_outputs", {timeout, resp_r1, resp_data, spi_data_out, spi_bits, spi_divider},
        {1'b0, 8'h00, 32'd0, 8'hFF, 5'd0, 8'd0});
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_cmd(vecs[i].idx, vecs[i].arg, vecs[i].crc, vecs[i].len, vecs[i].r1, vecs[i].dat,
              vecs[i].div, 0, vecs[i].chk_last, vecs[i].exp_last, $sformatf("vec%0d", i));

    // cmd_start during CMD byte 2 leaves the frame untouched
    run_cmd(6'd17, 32'h0BAD_F00D, 7'h2A, 3'd2, 8'h00, 32'h5A5A_0000, 8'h33, 1, 0, 8'h00, "inject");

    for (int i = 0; i < 25; i++) begin
      logic [7:0] r1;
      r1 = 8'($urandom);
      if ($urandom_range(0, 3) != 0) r1[7] = 1'b0;
      run_cmd(6'($urandom), $urandom, 7'($urandom), 3'($urandom_range(0, 7)), r1, $urandom,
              8'($urandom), 0, 0, 8'h00, $sformatf("rnd%0d", i));
    end

    // reset in the middle of the response phase aborts the command
    log_q.delete(); r1_cfg = 8'h00; data_cfg = 32'h1122_3344;
    @(negedge clk);
    cmd_index = 6'd8; cmd_arg = 32'h1AA; resp_len = 3'd4; clk_div = 8'h44; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cyc = 0;
    while (log_q.size() < 9 && cyc < 5000) begin @(negedge clk); cyc++; end
    chk("abort_reached_resp", 64'(log_q.size() >= 9), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_outputs", {resp_r1, resp_data, spi_divider}, {8'h00, 32'd0, 8'd0});
    cnt_done = 0; cnt_start = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (spi_start) cnt_start++;
    end
    chk("abort_no_done", 64'(cnt_done), 64'd0);
    chk("abort_no_spi_start", 64'(cnt_start), 64'd0);

    // reset wins over a simultaneous cmd_start
    @(negedge clk);
    rst = 1'b1; cmd_start = 1'b1;
    @(negedge clk);
    rst = 1'b0; cmd_start = 1'b0;
    @(negedge clk);
    chk("rst_priority_busy", busy, 1'b0);
    chk("rst_priority_spi_start", spi_start, 1'b0);

    // the block still works after the abort
    run_cmd(6'd0, 32'h0, 7'h4A, 3'd0, 8'h01, 32'h0, 8'h20, 0, 1, 8'h95, "post_abort");

    chk("one_outstanding", 64'(viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
